// File: rtl/gs_frame_ctrl_if.sv
// Handshake bundle between the frame controller, the RGB input FIFO,
// the grayscale stage and the gray output FIFO.
interface gs_frame_ctrl_if;
    logic fifo_in_empty;
    logic fifo_in_rd_en;
    logic stage_in_empty;
    logic stage_in_rd_en;
    logic stage_out_wr_en;
    logic stage_out_full;
    logic fifo_out_full;
    logic fifo_out_wr_en;

    // Controller side
    modport master (
        input  fifo_in_empty, stage_in_rd_en, stage_out_wr_en, fifo_out_full,
        output fifo_in_rd_en, stage_in_empty, stage_out_full, fifo_out_wr_en
    );

    // FIFO / stage side
    modport slave (
        output fifo_in_empty, stage_in_rd_en, stage_out_wr_en, fifo_out_full,
        input  fifo_in_rd_en, stage_in_empty, stage_out_full, fifo_out_wr_en
    );
endinterface

// File: rtl/gs_frame_ctrl.sv
// Frame sequencer for the grayscale stage: admits exactly WIDTH*HEIGHT
// pixels per start, tracks row/col of the next pixel, counts gray writes
// and pulses done once the stage has drained the frame.
module gs_frame_ctrl #(
    parameter int WIDTH  = 720,
    parameter int HEIGHT = 540,
    parameter int COL_W  = 10,
    parameter int ROW_W  = 10,
    parameter int CNT_W  = 20
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [COL_W-1:0] col_o,
    output logic [ROW_W-1:0] row_o,
    output logic             sof_o,
    gs_frame_ctrl_if.master  bus
);
    localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(WIDTH*HEIGHT - 1);
    localparam logic [CNT_W-1:0] PIX_ALL  = CNT_W'(WIDTH*HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t           state_q;
    logic             busy_q, done_q, err_q, err_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    logic run, start_ok, rd_adm, wr_fwd, wr_ok, wr_bad, last_rd, last_wr;

    // Handshake gating and event decode
    always_comb begin
        run      = (state_q == S_RUN);
        start_ok = (state_q == S_IDLE) && start_i;
        rd_adm   = bus.stage_in_rd_en && run && !bus.fifo_in_empty;
        wr_fwd   = bus.stage_out_wr_en && !bus.fifo_out_full;
        // A forwarded write only counts while a frame is open and not yet full.
        wr_ok    = wr_fwd && (state_q == S_RUN || state_q == S_DRAIN) && (wr_cnt_q != PIX_ALL);
        wr_bad   = wr_fwd && !wr_ok;
        last_rd  = rd_adm && (rd_cnt_q == PIX_LAST);
        last_wr  = wr_ok && (state_q == S_DRAIN) && (wr_cnt_q == PIX_LAST);
    end

    assign bus.stage_in_empty = bus.fifo_in_empty || !run;
    assign bus.fifo_in_rd_en  = rd_adm;
    // Output side is never gated by state so the stage can always drain.
    assign bus.stage_out_full = bus.fifo_out_full;
    assign bus.fifo_out_wr_en = wr_fwd;

    // Next-state for counters, position and sticky error
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        col_d    = col_q;
        row_d    = row_q;
        err_d    = err_q || wr_bad;
        if (start_ok) begin
            rd_cnt_d = '0;
            wr_cnt_d = '0;
            col_d    = '0;
            row_d    = '0;
        end else begin
            if (rd_adm) begin
                rd_cnt_d = rd_cnt_q + 1'b1;
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            if (wr_ok) wr_cnt_d = wr_cnt_q + 1'b1;
        end
    end

    // Counter / position / error registers
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            col_q    <= '0;
            row_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            col_q    <= col_d;
            row_q    <= row_d;
            err_q    <= err_d;
        end
    end

    // Frame FSM with registered busy/done
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (start_i) begin
                    state_q <= S_RUN;
                    busy_q  <= 1'b1;
                end
                S_RUN: if (last_rd) state_q <= S_DRAIN;
                S_DRAIN: if (last_wr) begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign err_o  = err_q;
    assign col_o  = col_q;
    assign row_o  = row_q;
    assign sof_o  = run && (row_q == '0) && (col_q == '0);
endmodule
